mccoy_prog_buffer: RTL and testbench

//  Upstream instruction source for the McCoy core. Captures a short program (6-bit words) from the

---
 rtl/mccoy_pkg.sv | 20 ++
 rtl/mccoy_prog_mem.sv | 40 ++++
 rtl/mccoy_prog_buffer.sv | 135 +++++++++++++
 tb/tb_mccoy_prog_buffer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mccoy_pkg.sv
// ---------------------------------------------------------------------------
// mccoy_pkg
// Shared definitions for the McCoy program buffer: controller state encoding,
// instruction width and the filler word driven when no valid program word
// is addressed.
// ---------------------------------------------------------------------------
package mccoy_pkg;

    // Controller states. Encodings are fixed so they read the same in waves
    // and in any software model of the buffer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no program held
        ST_LOAD = 2'd1,   // 1..DEPTH words held, core in reset
        ST_RUN  = 2'd2    // core released, executing buffered program
    } state_t;

    localparam int                   INSTR_W        = 6;
    localparam logic [INSTR_W-1:0]   FILL_INSTR_DEF = 6'h00;

endpackage : mccoy_pkg

// File: rtl/mccoy_prog_mem.sv
// ---------------------------------------------------------------------------
// mccoy_prog_mem
// DEPTH x IW program store. Synchronous write, asynchronous read so the
// single-cycle core gets its instruction in the same cycle its PC changes.
//
// Ports
//   clk    in   1    write clock
//   we     in   1    write enable
//   waddr  in   AW   write address
//   wdata  in   IW   write data
//   raddr  in   AW   read address
//   rdata  out  IW   read data (combinational)
// ---------------------------------------------------------------------------
module mccoy_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the owner's word count gates visibility,
    // so stale contents can never reach the core and the array stays a plain
    // register file without a reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : mccoy_prog_mem

// File: rtl/mccoy_prog_buffer.sv
// ---------------------------------------------------------------------------
// mccoy_prog_buffer
// Instruction source for the McCoy core. Captures a short program from the
// load pins, then replays it indexed by the core's PC. Holds the core in
// reset until a program is present and a run request arrives.
//
// Ports
//   clk         in   1      single clock
//   reset       in   1      synchronous, active-low
//   load_valid  in   1      load_data carries a program word
//   load_data   in   IW     program word
//   load_ready  out  1      buffer accepts a word this cycle
//   run         in   1      release core and execute program
//   stop        in   1      halt core, keep program
//   clear       in   1      discard program
//   pc          in   8      core program counter
//   instr       out  IW     instruction to core (combinational from pc)
//   pc_oob      out  1      pc >= count
//   core_rst    out  1      active-high core reset, registered
//   count       out  AW+1   words loaded, 0..DEPTH
// ---------------------------------------------------------------------------
module mccoy_prog_buffer
    import mccoy_pkg::*;
#(
    parameter int              DEPTH      = 16,
    parameter int              AW         = 4,
    parameter int              IW         = INSTR_W,
    parameter logic [IW-1:0]   FILL_INSTR = FILL_INSTR_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    output logic          load_ready,
    input  logic          run,
    input  logic          stop,
    input  logic          clear,
    input  logic [7:0]    pc,
    output logic [IW-1:0] instr,
    output logic          pc_oob,
    output logic          core_rst,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        state;
    state_t        next_state;
    logic [AW:0]   next_count;
    logic          do_write;
    logic          wr_acc;
    logic [IW-1:0] mem_rdata;

    assign load_ready = (state != ST_RUN) && (count != FULL);
    assign wr_acc     = load_valid && load_ready;

    // Next-state / count logic. clear has priority over run and over a
    // same-cycle write; stop has priority over run while running.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and no latch is inferred.
        next_state = state;
        next_count = count;
        do_write   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!clear && wr_acc) begin
                    do_write   = 1'b1;
                    next_count = count + 1'b1;
                    // A run that coincides with the first word launches the
                    // one-word program directly.
                    next_state = run ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (clear) begin
                    next_state = ST_IDLE;
                    next_count = '0;
                end else begin
                    if (wr_acc) begin
                        do_write   = 1'b1;
                        next_count = count + 1'b1;
                    end
                    // count is non-zero in LOAD, so run is always honoured.
                    if (run) begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    next_state = ST_LOAD;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            core_rst <= 1'b1;
        end else begin
            state    <= next_state;
            count    <= next_count;
            // Registered from next_state so the core leaves reset on the very
            // first RUN cycle and re-enters it on the first cycle after.
            core_rst <= (next_state != ST_RUN);
        end
    end

    mccoy_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .we    (do_write && reset),
        .waddr (count[AW-1:0]),
        .wdata (load_data),
        .raddr (pc[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Full-width compare: pc values beyond DEPTH must not alias onto low
    // words through the truncated read address.
    assign pc_oob = (pc >= 8'(count));
    assign instr  = pc_oob ? FILL_INSTR : mem_rdata;

endmodule : mccoy_prog_buffer

// File: tb/tb_mccoy_prog_buffer.sv
// ---------------------------------------------------------------------------
// tb_mccoy_prog_buffer
// Directed bench for mccoy_prog_buffer. Stimulus pushes hand-computed
// expected outputs into a queue; a monitor on the falling edge pops each
// entry and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_mccoy_prog_buffer;

    typedef struct {
        string      name;
        logic [5:0] instr;
        logic       pc_oob;
        logic [4:0] count;
        logic       core_rst;
        logic       load_ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_ready;
    logic       run;
    logic       stop;
    logic       clear;
    logic [7:0] pc;
    logic [5:0] instr;
    logic       pc_oob;
    logic       core_rst;
    logic [4:0] count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mccoy_prog_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .run        (run),
        .stop       (stop),
        .clear      (clear),
        .pc         (pc),
        .instr      (instr),
        .pc_oob     (pc_oob),
        .core_rst   (core_rst),
        .count      (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".instr"},      32'(instr),      32'(e.instr));
                check({e.name, ".pc_oob"},     32'(pc_oob),     32'(e.pc_oob));
                check({e.name, ".count"},      32'(count),      32'(e.count));
                check({e.name, ".core_rst"},   32'(core_rst),   32'(e.core_rst));
                check({e.name, ".load_ready"}, 32'(load_ready), 32'(e.load_ready));
            end
        end
    end

    // One clock with the given inputs, then return all requests to idle.
    task automatic cyc(input logic lv, input logic [5:0] d, input logic r,
                       input logic s, input logic c);
        load_valid = lv;
        load_data  = d;
        run        = r;
        stop       = s;
        clear      = c;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 6'h00;
        run        = 1'b0;
        stop       = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic exp(input string name, input logic [7:0] p, input logic [5:0] ins,
                       input logic oob, input logic [4:0] cnt, input logic crst,
                       input logic rdy);
        exp_t e;
        pc = p;
        e.name = name; e.instr = ins; e.pc_oob = oob;
        e.count = cnt; e.core_rst = crst; e.load_ready = rdy;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = 6'h00;
        run = 1'b0; stop = 1'b0; clear = 1'b0; pc = 8'h00;

        // 1: reset held two cycles
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp("rst", 8'h00, 6'h00, 1'b1, 5'd0, 1'b1, 1'b1);

        // 2: three words then run
        cyc(1'b1, 6'h0A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 6'h15, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 6'h2C, 1'b0, 1'b0, 1'b0);
        exp("load3", 8'h00, 6'h0A, 1'b0, 5'd3, 1'b1, 1'b1);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        exp("run_pc1",  8'h01, 6'h15, 1'b0, 5'd3, 1'b0, 1'b0);
        exp("run_pc2",  8'h02, 6'h2C, 1'b0, 5'd3, 1'b0, 1'b0);
        exp("run_pc3",  8'h03, 6'h00, 1'b1, 5'd3, 1'b0, 1'b0);
        exp("run_pc11", 8'h11, 6'h00, 1'b1, 5'd3, 1'b0, 1'b0);

        // 1b: reset mid-RUN, with run and a word offered alongside
        reset = 1'b0;
        cyc(1'b1, 6'h3F, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        exp("rst_run", 8'h00, 6'h00, 1'b1, 5'd0, 1'b1, 1'b1);

        // 3: seventeen words, last one dropped
        for (int i = 1; i <= 16; i++) cyc(1'b1, 6'(i), 1'b0, 1'b0, 1'b0);
        exp("full16", 8'h0F, 6'd16, 1'b0, 5'd16, 1'b1, 1'b0);
        cyc(1'b1, 6'd17, 1'b0, 1'b0, 1'b0);
        exp("drop17",  8'h00, 6'd1,  1'b0, 5'd16, 1'b1, 1'b0);
        exp("nowrap",  8'h10, 6'h00, 1'b1, 5'd16, 1'b1, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        exp("clr_full", 8'h00, 6'h00, 1'b1, 5'd0, 1'b1, 1'b1);

        // 4: first word and run together from IDLE
        cyc(1'b1, 6'h07, 1'b1, 1'b0, 1'b0);
        exp("wr_run_pc0", 8'h00, 6'h07, 1'b0, 5'd1, 1'b0, 1'b0);
        exp("wr_run_pc1", 8'h01, 6'h00, 1'b1, 5'd1, 1'b0, 1'b0);

        // 5: stop+run in RUN -> LOAD; append; run; clear ignored in RUN
        cyc(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        exp("stop_wins", 8'h00, 6'h07, 1'b0, 5'd1, 1'b1, 1'b1);
        cyc(1'b1, 6'h3F, 1'b0, 1'b0, 1'b0);
        exp("append", 8'h01, 6'h3F, 1'b0, 5'd2, 1'b1, 1'b1);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        exp("rerun", 8'h00, 6'h07, 1'b0, 5'd2, 1'b0, 1'b0);
        cyc(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        exp("clr_in_run", 8'h01, 6'h3F, 1'b0, 5'd2, 1'b0, 1'b0);

        // 6: clear beats a same-cycle write in LOAD; run in IDLE ignored
        cyc(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
        exp("stop", 8'h00, 6'h07, 1'b0, 5'd2, 1'b1, 1'b1);
        cyc(1'b1, 6'h11, 1'b0, 1'b0, 1'b1);
        exp("clr_wr", 8'h00, 6'h00, 1'b1, 5'd0, 1'b1, 1'b1);
        cyc(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        exp("idle_run", 8'h00, 6'h00, 1'b1, 5'd0, 1'b1, 1'b1);
        cyc(1'b1, 6'h22, 1'b0, 1'b0, 1'b0);
        exp("reload", 8'h00, 6'h22, 1'b0, 5'd1, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mccoy_prog_buffer
